axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Shares one downstream AXI4 read port (AR + R channels) between the core's instruction-side and data-side read masters.
- Sits between riscv_top's axi_i/axi_d read outputs and a single memory model or memory controller.
- Grants one burst at a time, registers the AR request, and routes R beats back to the owning master until the rlast handshake.
- Flags bursts whose beat count does not match arlen.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, read data width
ID_W, 4, AXI ID width
FIXED_PRIO, 0, 0 = round-robin; 1 = port 1 (D-side) always wins ties

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  asynchronous active-high reset
s0_arvalid_i / s1_arvalid_i  in  1  AR valid from I-side / D-side
s0_arready_o / s1_arready_o  out  1  AR accepted
s0_araddr_i / s1_araddr_i  in  ADDR_W  AR address
s0_arid_i / s1_arid_i  in  ID_W  AR ID
s0_arlen_i / s1_arlen_i  in  8  burst length minus 1
s0_arburst_i / s1_arburst_i  in  2  burst type, passed through
s0_rvalid_o / s1_rvalid_o  out  1  R valid, owner only
s0_rready_i / s1_rready_i  in  1  R ready
s0_rdata_o / s1_rdata_o  out  DATA_W  R data (broadcast)
s0_rresp_o / s1_rresp_o  out  2  R response (broadcast)
s0_rid_o / s1_rid_o  out  ID_W  R ID (broadcast)
s0_rlast_o / s1_rlast_o  out  1  R last, owner only
m_arvalid_o  out  1  downstream AR valid
m_arready_i  in  1  downstream AR ready
m_araddr_o, m_arid_o, m_arlen_o, m_arburst_o  out  ADDR_W/ID_W/8/2  registered AR fields
m_rvalid_i, m_rdata_i, m_rresp_i, m_rid_i, m_rlast_i  in  1/DATA_W/2/ID_W/1  downstream R channel
m_rready_o  out  1  downstream R ready
grant_o  out  2  one-hot current owner; 0 in IDLE
len_err_o  out  1  sticky burst-length mismatch flag

Behaviour:
- Reset (async, rst_i=1): state=IDLE; m_arvalid_o=0; m_ar* fields=0; grant_o=0; len_err_o=0; beat counter=0; last_grant=port1, so port0 wins the first tie. All s*_arready_o, s*_rvalid_o, s*_rlast_o and m_rready_o read 0. Reset mid-burst abandons the burst with no further R routing.
- States: IDLE, ADDR, DATA.
- IDLE, arbitration:
  - Only one port valid: it wins.
  - Both valid, FIXED_PRIO=0: the port not equal to last_grant wins.
  - Both valid, FIXED_PRIO=1: port1 wins.
  - sX_arready_o = (state==IDLE) && winner==X, combinational. It is high only in the capture cycle.
  - On the handshake: capture addr/id/len/burst into m_ar* registers, set grant_o and last_grant, go to ADDR.
- ADDR:
  - m_arvalid_o=1 with stable fields.
  - On m_arready_i, go to DATA and clear the beat counter.
  - First m_arvalid_o is the cycle after the upstream handshake (1-cycle latency).
  - No upstream arready is asserted outside IDLE.
- DATA:
  - Owner's rvalid_o = m_rvalid_i and rlast_o = m_rlast_i; the non-owner's are 0.
  - m_rready_o = owner's rready_i.
  - rdata/rresp/rid are driven to both ports, combinational pass-through (zero added latency).
  - Each beat handshake (m_rvalid_i && m_rready_o) increments the 8-bit beat counter. The counter saturates at 255.
- Last beat:
  - A handshake with m_rlast_i returns to IDLE and clears grant_o.
  - A new AR may be accepted in the next cycle, not the same cycle.
- Length check on each beat:
  - Set len_err_o if rlast is seen with counter != captured arlen.
  - Set len_err_o if counter == arlen and rlast is absent.
  - After an error the burst continues until rlast.
  - len_err_o clears only on reset.
- m_rvalid_i while in IDLE or ADDR: ignored; m_rready_o=0.
- Upstream masters must hold AR stable until arready; the arbiter does not check this.

Test Plan:
- Single I-side burst: s0 AR addr=0x100, len=3; slave ready. Required: s0_arready_o in cycle N; m_arvalid_o in N+1 with addr 0x100, len 3; 4 beats reach s0 only; s0_rlast_o on beat 4; grant_o returns 0; len_err_o stays 0.
- Simultaneous requests, FIXED_PRIO=0, from reset: both valid, len=0. Required: port0 granted first, then port1. Repeat the pair: order is port0 then port1 again.
- Simultaneous requests, FIXED_PRIO=1: port1 is always granted first over three repeated pairs.
- Backpressure: s1 burst len=1 with s1_rready_i low 5 cycles. Required: m_rready_o low for those cycles; no beat is lost; the beat counter advances only on handshakes.
- Length error: len=3, slave asserts rlast on beat 2. Required: len_err_o=1 from the cycle after beat 2; return to IDLE; the flag remains set through the next clean burst.
- Reset mid-DATA: assert rst_i after beat 1 of a len=7 burst. Required: all outputs 0 immediately; after release, a new port0 request is granted normally.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// AXI4 read arbiter: one downstream AR/R port shared by an I-side master (port 0)
// and a D-side master (port 1), one burst at a time, with burst-length checking.
module axi_rd_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              s0_arvalid_i,
  output logic              s0_arready_o,
  input  logic [ADDR_W-1:0] s0_araddr_i,
  input  logic [ID_W-1:0]   s0_arid_i,
  input  logic [7:0]        s0_arlen_i,
  input  logic [1:0]        s0_arburst_i,
  output logic              s0_rvalid_o,
  input  logic              s0_rready_i,
  output logic [DATA_W-1:0] s0_rdata_o,
  output logic [1:0]        s0_rresp_o,
  output logic [ID_W-1:0]   s0_rid_o,
  output logic              s0_rlast_o,
  input  logic              s1_arvalid_i,
  output logic              s1_arready_o,
  input  logic [ADDR_W-1:0] s1_araddr_i,
  input  logic [ID_W-1:0]   s1_arid_i,
  input  logic [7:0]        s1_arlen_i,
  input  logic [1:0]        s1_arburst_i,
  output logic              s1_rvalid_o,
  input  logic              s1_rready_i,
  output logic [DATA_W-1:0] s1_rdata_o,
  output logic [1:0]        s1_rresp_o,
  output logic [ID_W-1:0]   s1_rid_o,
  output logic              s1_rlast_o,
  output logic              m_arvalid_o,
  input  logic              m_arready_i,
  output logic [ADDR_W-1:0] m_araddr_o,
  output logic [ID_W-1:0]   m_arid_o,
  output logic [7:0]        m_arlen_o,
  output logic [1:0]        m_arburst_o,
  input  logic              m_rvalid_i,
  input  logic [DATA_W-1:0] m_rdata_i,
  input  logic [1:0]        m_rresp_i,
  input  logic [ID_W-1:0]   m_rid_i,
  input  logic              m_rlast_i,
  output logic              m_rready_o,
  output logic [1:0]        grant_o,
  output logic              len_err_o
);
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned BURST_W = 2;
  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  state_t              state_q, state_d;
  logic                arvalid_q;
  logic [ADDR_W-1:0]   araddr_q;
  logic [ID_W-1:0]     arid_q;
  logic [LEN_W-1:0]    arlen_q;
  logic [BURST_W-1:0]  arburst_q;
  logic [1:0]          grant_q;
  logic                last_grant_q;   // 1 = port 1 owned the previous burst
  logic                len_err_q;
  logic [LEN_W-1:0]    beat_cnt_q;

  logic any_req, win1, ar_take, in_data, own1, beat_hs, len_bad;

  // Winner selection; ties go to the port that was not served last unless fixed priority
  always_comb begin
    win1 = s1_arvalid_i;
    if (s0_arvalid_i && s1_arvalid_i) begin
      win1 = (FIXED_PRIO != 0) ? 1'b1 : ~last_grant_q;
    end
  end

  assign any_req      = s0_arvalid_i | s1_arvalid_i;
  assign ar_take      = (state_q == ST_IDLE) && any_req;
  assign s0_arready_o = ar_take && !win1 && !rst_i;
  assign s1_arready_o = ar_take && win1 && !rst_i;

  // R routing: valid/last only to the owner, payload broadcast
  assign in_data     = (state_q == ST_DATA);
  assign own1        = grant_q[1];
  assign m_rready_o  = in_data && (own1 ? s1_rready_i : s0_rready_i);
  assign s0_rvalid_o = in_data && !own1 && m_rvalid_i;
  assign s1_rvalid_o = in_data && own1 && m_rvalid_i;
  assign s0_rlast_o  = in_data && !own1 && m_rlast_i;
  assign s1_rlast_o  = in_data && own1 && m_rlast_i;
  assign s0_rdata_o  = m_rdata_i;
  assign s1_rdata_o  = m_rdata_i;
  assign s0_rresp_o  = m_rresp_i;
  assign s1_rresp_o  = m_rresp_i;
  assign s0_rid_o    = m_rid_i;
  assign s1_rid_o    = m_rid_i;

  assign beat_hs = m_rvalid_i && m_rready_o;
  assign len_bad = beat_hs && (m_rlast_i ? (beat_cnt_q != arlen_q) : (beat_cnt_q == arlen_q));

  assign m_arvalid_o = arvalid_q;
  assign m_araddr_o  = araddr_q;
  assign m_arid_o    = arid_q;
  assign m_arlen_o   = arlen_q;
  assign m_arburst_o = arburst_q;
  assign grant_o     = grant_q;
  assign len_err_o   = len_err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_req)                  state_d = ST_ADDR;
      ST_ADDR: if (m_arready_i)              state_d = ST_DATA;
      ST_DATA: if (beat_hs && m_rlast_i)     state_d = ST_IDLE;
      default:                               state_d = ST_IDLE;
    endcase
  end

  // AR capture, ownership, beat counting and the sticky length-error flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      arid_q       <= '0;
      arlen_q      <= '0;
      arburst_q    <= '0;
      grant_q      <= '0;
      last_grant_q <= 1'b1;
      len_err_q    <= 1'b0;
      beat_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            arvalid_q    <= 1'b1;
            araddr_q     <= win1 ? s1_araddr_i  : s0_araddr_i;
            arid_q       <= win1 ? s1_arid_i    : s0_arid_i;
            arlen_q      <= win1 ? s1_arlen_i   : s0_arlen_i;
            arburst_q    <= win1 ? s1_arburst_i : s0_arburst_i;
            grant_q      <= win1 ? 2'b10 : 2'b01;
            last_grant_q <= win1;
          end
        end
        ST_ADDR: begin
          if (m_arready_i) begin
            arvalid_q  <= 1'b0;
            beat_cnt_q <= '0;
          end
        end
        ST_DATA: begin
          if (beat_hs) begin
            if (beat_cnt_q != CNT_MAX) beat_cnt_q <= beat_cnt_q + LEN_W'(1);
            if (len_bad)               len_err_q  <= 1'b1;
            if (m_rlast_i)             grant_q    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: instance 0 round-robin, instance 1 fixed priority,
// each checked every cycle against a transaction-level model plus directed literals.
module tb_axi_rd_arbiter;
  logic clk;
  logic rst [2];
  logic        arvalid [2][2];
  logic [31:0] araddr  [2][2];
  logic [3:0]  arid    [2][2];
  logic [7:0]  arlen   [2][2];
  logic [1:0]  arburst [2][2];
  logic        rready  [2][2];
  logic        m_arready [2];
  logic        m_rvalid  [2];
  logic        m_rlast   [2];
  logic [31:0] m_rdata   [2];
  logic [1:0]  m_rresp   [2];
  logic [3:0]  m_rid     [2];

  wire        arready_w [2][2];
  wire        rvalid_w  [2][2];
  wire        rlast_w   [2][2];
  wire [31:0] rdata_w   [2][2];
  wire [1:0]  rresp_w   [2][2];
  wire [3:0]  rid_w     [2][2];
  wire        m_arvalid_w [2];
  wire        m_rready_w  [2];
  wire        len_err_w   [2];
  wire [31:0] m_araddr_w  [2];
  wire [3:0]  m_arid_w    [2];
  wire [7:0]  m_arlen_w   [2];
  wire [1:0]  m_arburst_w [2];
  wire [1:0]  grant_w     [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .FIXED_PRIO(g)) u_dut (
      .clk_i(clk), .rst_i(rst[g]),
      .s0_arvalid_i(arvalid[g][0]), .s0_arready_o(arready_w[g][0]), .s0_araddr_i(araddr[g][0]),
      .s0_arid_i(arid[g][0]), .s0_arlen_i(arlen[g][0]), .s0_arburst_i(arburst[g][0]),
      .s0_rvalid_o(rvalid_w[g][0]), .s0_rready_i(rready[g][0]), .s0_rdata_o(rdata_w[g][0]),
      .s0_rresp_o(rresp_w[g][0]), .s0_rid_o(rid_w[g][0]), .s0_rlast_o(rlast_w[g][0]),
      .s1_arvalid_i(arvalid[g][1]), .s1_arready_o(arready_w[g][1]), .s1_araddr_i(araddr[g][1]),
      .s1_arid_i(arid[g][1]), .s1_arlen_i(arlen[g][1]), .s1_arburst_i(arburst[g][1]),
      .s1_rvalid_o(rvalid_w[g][1]), .s1_rready_i(rready[g][1]), .s1_rdata_o(rdata_w[g][1]),
      .s1_rresp_o(rresp_w[g][1]), .s1_rid_o(rid_w[g][1]), .s1_rlast_o(rlast_w[g][1]),
      .m_arvalid_o(m_arvalid_w[g]), .m_arready_i(m_arready[g]), .m_araddr_o(m_araddr_w[g]),
      .m_arid_o(m_arid_w[g]), .m_arlen_o(m_arlen_w[g]), .m_arburst_o(m_arburst_w[g]),
      .m_rvalid_i(m_rvalid[g]), .m_rdata_i(m_rdata[g]), .m_rresp_i(m_rresp[g]),
      .m_rid_i(m_rid[g]), .m_rlast_i(m_rlast[g]), .m_rready_o(m_rready_w[g]),
      .grant_o(grant_w[g]), .len_err_o(len_err_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc;
  int glog[$];
  int bad_last [2];
  int sl_left [2];
  int sl_beat [2];
  int bc [2][2];
  int lc [2][2];
  int ar_cyc [2];
  int rise_cyc [2];
  logic prev_arv [2];

  // Model: per instance, an outstanding burst (busy), whether its AR went downstream
  bit          mb [2];
  bit          ms [2];
  int          mown [2];
  int          mlast [2];
  bit          merr [2];
  int          mbeats [2];
  logic [31:0] maddr [2];
  logic [3:0]  mid [2];
  logic [7:0]  mlen [2];
  logic [1:0]  mburst [2];

  task automatic chk(input string nm, input int k, input int p, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst=%0d port=%0d t=%0t: got %0h, expected %0h", nm, k, p, $time, act, exp);
    end
  endtask

  function automatic int pick(input int k);
    if (arvalid[k][0] && arvalid[k][1]) return (k == 1) ? 1 : ((mlast[k] == 1) ? 0 : 1);
    if (arvalid[k][0]) return 0;
    if (arvalid[k][1]) return 1;
    return -1;
  endfunction

  // Per-cycle compare against the model, then advance the model across the next edge
  initial begin
    cyc = 0;
    for (int k = 0; k < 2; k++) begin
      prev_arv[k] = 1'b0; ar_cyc[k] = 0; rise_cyc[k] = 0;
      for (int p = 0; p < 2; p++) begin bc[k][p] = 0; lc[k][p] = 0; end
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        int  w;
        int  o;
        bit  dat;
        if (rst[k]) begin
          mb[k] = 0; ms[k] = 0; mown[k] = 0; mlast[k] = 1; merr[k] = 0; mbeats[k] = 0;
          maddr[k] = '0; mid[k] = '0; mlen[k] = '0; mburst[k] = '0;
        end
        w   = pick(k);
        o   = mown[k];
        dat = mb[k] && ms[k];
        for (int p = 0; p < 2; p++) begin
          chk("arready", k, p, 32'(arready_w[k][p]), 32'(!rst[k] && !mb[k] && (w == p)));
          chk("rvalid",  k, p, 32'(rvalid_w[k][p]),  32'(dat && (o == p) && m_rvalid[k]));
          chk("rlast",   k, p, 32'(rlast_w[k][p]),   32'(dat && (o == p) && m_rlast[k]));
          chk("rdata",   k, p, rdata_w[k][p],        m_rdata[k]);
          chk("rresp",   k, p, 32'(rresp_w[k][p]),   32'(m_rresp[k]));
          chk("rid",     k, p, 32'(rid_w[k][p]),     32'(m_rid[k]));
        end
        chk("m_arvalid", k, -1, 32'(m_arvalid_w[k]), 32'(mb[k] && !ms[k]));
        chk("m_araddr",  k, -1, m_araddr_w[k],       maddr[k]);
        chk("m_arid",    k, -1, 32'(m_arid_w[k]),    32'(mid[k]));
        chk("m_arlen",   k, -1, 32'(m_arlen_w[k]),   32'(mlen[k]));
        chk("m_arburst", k, -1, 32'(m_arburst_w[k]), 32'(mburst[k]));
        chk("m_rready",  k, -1, 32'(m_rready_w[k]),  32'(dat && rready[k][o]));
        chk("grant",     k, -1, 32'(grant_w[k]),     mb[k] ? ((o == 0) ? 32'd1 : 32'd2) : 32'd0);
        chk("len_err",   k, -1, 32'(len_err_w[k]),   32'(merr[k]));

        for (int p = 0; p < 2; p++) begin
          if (rvalid_w[k][p] && rready[k][p]) begin
            bc[k][p]++;
            if (rlast_w[k][p]) lc[k][p]++;
          end
          if (arready_w[k][p] && arvalid[k][p]) ar_cyc[k] = cyc;
        end
        if (m_arvalid_w[k] && !prev_arv[k]) rise_cyc[k] = cyc;
        prev_arv[k] = m_arvalid_w[k];

        if (!rst[k]) begin
          if (!mb[k] && w >= 0) begin
            mb[k] = 1; ms[k] = 0; mown[k] = w; mlast[k] = w;
            maddr[k] = araddr[k][w]; mid[k] = arid[k][w];
            mlen[k] = arlen[k][w]; mburst[k] = arburst[k][w];
          end else if (mb[k] && !ms[k] && m_arready[k]) begin
            ms[k] = 1; mbeats[k] = 0;
          end else if (dat && m_rvalid[k] && rready[k][o]) begin
            if (m_rlast[k] ? (mbeats[k] != int'(mlen[k])) : (mbeats[k] == int'(mlen[k]))) merr[k] = 1;
            if (mbeats[k] < 255) mbeats[k]++;
            if (m_rlast[k]) mb[k] = 0;
          end
        end
      end
    end
  end

  // Downstream slave: always ready for AR, returns arlen+1 beats (or bad_last+1 when set)
  initial begin
    bit         ar_hs_s [2];
    bit         r_hs_s  [2];
    bit         rst_s   [2];
    logic [7:0] len_s   [2];
    for (int k = 0; k < 2; k++) begin
      m_arready[k] = 1'b1; m_rvalid[k] = 1'b0; m_rlast[k] = 1'b0;
      m_rdata[k] = '0; m_rresp[k] = '0; m_rid[k] = '0;
      sl_left[k] = 0; sl_beat[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        ar_hs_s[k] = m_arvalid_w[k] && m_arready[k] && !rst[k];
        r_hs_s[k]  = m_rvalid[k] && m_rready_w[k] && !rst[k];
        rst_s[k]   = rst[k];
        len_s[k]   = m_arlen_w[k];
      end
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        bit drive;
        drive = 0;
        if (rst_s[k] || rst[k]) begin
          sl_left[k] = 0; m_rvalid[k] = 1'b0; m_rlast[k] = 1'b0;
        end else if (ar_hs_s[k]) begin
          sl_left[k] = (bad_last[k] >= 0) ? bad_last[k] + 1 : int'(len_s[k]) + 1;
          sl_beat[k] = 0;
          drive = 1;
        end else if (r_hs_s[k]) begin
          sl_beat[k]++;
          if (sl_beat[k] >= sl_left[k]) begin
            sl_left[k] = 0; m_rvalid[k] = 1'b0; m_rlast[k] = 1'b0;
          end else drive = 1;
        end
        if (drive) begin
          m_rvalid[k] = 1'b1;
          m_rdata[k]  = 32'hD000_0000 + 32'(k << 16) + 32'(sl_beat[k]);
          m_rresp[k]  = 2'(sl_beat[k]);
          m_rid[k]    = 4'(sl_beat[k] + 5 * k);
          m_rlast[k]  = (sl_beat[k] == sl_left[k] - 1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int k);
    rst[k] = 1'b1;
    tick(); tick();
    rst[k] = 1'b0;
  endtask

  // Present AR on the selected ports and hold each until accepted; logs grant order
  task automatic ar_pair(input int k, input bit v0, input bit v1, input logic [31:0] a0,
                         input logic [31:0] a1, input logic [7:0] l0, input logic [7:0] l1);
    bit p0, p1, g0, g1;
    int n;
    arvalid[k][0] = v0; araddr[k][0] = a0; arlen[k][0] = l0; arid[k][0] = 4'h3; arburst[k][0] = 2'b01;
    arvalid[k][1] = v1; araddr[k][1] = a1; arlen[k][1] = l1; arid[k][1] = 4'hA; arburst[k][1] = 2'b10;
    p0 = v0; p1 = v1; n = 0;
    while ((p0 || p1) && n < 200) begin
      @(negedge clk);
      g0 = arvalid[k][0] && arready_w[k][0];
      g1 = arvalid[k][1] && arready_w[k][1];
      if (g0) glog.push_back(0);
      if (g1) glog.push_back(1);
      tick();
      if (g0) begin arvalid[k][0] = 1'b0; p0 = 0; end
      if (g1) begin arvalid[k][1] = 1'b0; p1 = 0; end
      n++;
    end
    chk("ar_accept_timeout", k, -1, 32'(p0 || p1), 32'd0);
  endtask

  task automatic wait_idle(input int k);
    bit done;
    int n;
    done = 0; n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      done = (grant_w[k] == 2'b00) && !m_arvalid_w[k] && (sl_left[k] == 0);
      n++;
    end
    tick();
    chk("burst_done_timeout", k, -1, 32'(done), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1, l0;
    bit got;
    int n;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; bad_last[k] = -1;
      for (int p = 0; p < 2; p++) begin
        arvalid[k][p] = 1'b0; araddr[k][p] = '0; arid[k][p] = '0;
        arlen[k][p] = '0; arburst[k][p] = '0; rready[k][p] = 1'b1;
      end
    end
    tick(); tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_grant", k, -1, 32'(grant_w[k]), 32'd0);
      chk("rst_len_err", k, -1, 32'(len_err_w[k]), 32'd0);
      chk("rst_m_arvalid", k, -1, 32'(m_arvalid_w[k]), 32'd0);
      chk("rst_m_araddr", k, -1, m_araddr_w[k], 32'd0);
    end
    tick();
    rst[0] = 1'b0; rst[1] = 1'b0;
    tick();

    // Single I-side burst, len 3
    glog.delete();
    b0 = bc[0][0]; b1 = bc[0][1]; l0 = lc[0][0];
    ar_pair(0, 1, 0, 32'h100, 32'h0, 8'd3, 8'd0);
    wait_idle(0);
    chk("t1_grants", 0, -1, 32'(glog.size()), 32'd1);
    chk("t1_winner", 0, -1, 32'(glog[0]), 32'd0);
    chk("t1_arvalid_latency", 0, -1, 32'(rise_cyc[0] - ar_cyc[0]), 32'd1);
    chk("t1_m_araddr", 0, -1, m_araddr_w[0], 32'h100);
    chk("t1_m_arlen", 0, -1, 32'(m_arlen_w[0]), 32'd3);
    chk("t1_s0_beats", 0, 0, 32'(bc[0][0] - b0), 32'd4);
    chk("t1_s1_beats", 0, 1, 32'(bc[0][1] - b1), 32'd0);
    chk("t1_s0_rlast", 0, 0, 32'(lc[0][0] - l0), 32'd1);
    chk("t1_len_err", 0, -1, 32'(len_err_w[0]), 32'd0);

    // Round-robin ties from reset: 0 then 1, twice
    do_reset(0);
    glog.delete();
    ar_pair(0, 1, 1, 32'h200, 32'h400, 8'd0, 8'd0);
    wait_idle(0);
    ar_pair(0, 1, 1, 32'h210, 32'h410, 8'd0, 8'd0);
    wait_idle(0);
    chk("t2_grants", 0, -1, 32'(glog.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t2_order", 0, i, 32'(glog[i]), 32'(i % 2));

    // Fixed priority: port 1 first in every tie
    do_reset(1);
    glog.delete();
    for (int i = 0; i < 3; i++) begin
      ar_pair(1, 1, 1, 32'h1000 + 32'(i), 32'h2000 + 32'(i), 8'd0, 8'd0);
      wait_idle(1);
    end
    chk("t3_grants", 1, -1, 32'(glog.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk("t3_order", 1, i, 32'(glog[i]), 32'((i + 1) % 2));

    // Backpressure on the D-side R channel
    rready[0][1] = 1'b0;
    b1 = bc[0][1];
    ar_pair(0, 0, 1, 32'h0, 32'h500, 8'd0, 8'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_rready_low", 0, 1, 32'(m_rready_w[0]), 32'd0);
      tick();
    end
    rready[0][1] = 1'b1;
    wait_idle(0);
    chk("t4_s1_beats", 0, 1, 32'(bc[0][1] - b1), 32'd2);
    chk("t4_len_err", 0, -1, 32'(len_err_w[0]), 32'd0);

    // Early rlast on beat 2 of a len-3 burst, then a clean burst
    bad_last[0] = 1;
    b0 = bc[0][0];
    ar_pair(0, 1, 0, 32'h600, 32'h0, 8'd3, 8'd0);
    wait_idle(0);
    chk("t5_s0_beats", 0, 0, 32'(bc[0][0] - b0), 32'd2);
    chk("t5_len_err_set", 0, -1, 32'(len_err_w[0]), 32'd1);
    bad_last[0] = -1;
    ar_pair(0, 0, 1, 32'h0, 32'h700, 8'd0, 8'd2);
    wait_idle(0);
    chk("t5_len_err_sticky", 0, -1, 32'(len_err_w[0]), 32'd1);

    // Reset after the first beat of a len-7 burst
    ar_pair(0, 1, 0, 32'h800, 32'h0, 8'd7, 8'd0);
    got = 0; n = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      got = rvalid_w[0][0] && rready[0][0];
      n++;
    end
    chk("t6_first_beat", 0, 0, 32'(got), 32'd1);
    tick();
    rst[0] = 1'b1;
    @(negedge clk);
    chk("t6_grant", 0, -1, 32'(grant_w[0]), 32'd0);
    chk("t6_m_arvalid", 0, -1, 32'(m_arvalid_w[0]), 32'd0);
    chk("t6_s0_rvalid", 0, 0, 32'(rvalid_w[0][0]), 32'd0);
    chk("t6_m_rready", 0, -1, 32'(m_rready_w[0]), 32'd0);
    chk("t6_len_err", 0, -1, 32'(len_err_w[0]), 32'd0);
    chk("t6_m_araddr", 0, -1, m_araddr_w[0], 32'd0);
    tick(); tick();
    rst[0] = 1'b0;
    tick();
    glog.delete();
    b0 = bc[0][0];
    ar_pair(0, 1, 0, 32'h900, 32'h0, 8'd1, 8'd0);
    wait_idle(0);
    chk("t6_regrant", 0, -1, 32'(glog.size()), 32'd1);
    chk("t6_regrant_port", 0, -1, 32'(glog[0]), 32'd0);
    chk("t6_m_araddr_new", 0, -1, m_araddr_w[0], 32'h900);
    chk("t6_s0_beats", 0, 0, 32'(bc[0][0] - b0), 32'd2);
    chk("t6_len_err_clean", 0, -1, 32'(len_err_w[0]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
